// File: rtl/sound_pkg.sv
// Shared source codes, FSM encoding and counter widths for the sound arbiter.
package sound_pkg;
  localparam int PHASE_W = 17;
  localparam int TICK_W  = 6;

  // Codes double as priorities: a larger code always wins.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_JUMP = 2'd1,
    SRC_MILE = 2'd2,
    SRC_OVER = 2'd3
  } src_t;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  function automatic src_t src_max(input src_t a, input src_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic src_t src_min(input src_t a, input src_t b);
    return (a > b) ? b : a;
  endfunction
endpackage

// File: rtl/sound_arbiter_tone_gen.sv
// Square-wave generator: phase counter that toggles the output each half period.
module tone_gen
  import sound_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] half,
  input  logic               clr,
  input  logic               en,
  output logic               sound
);
  logic [PHASE_W-1:0] phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      sound <= 1'b0;
    end else if (clr || !en) begin
      phase <= '0;
      sound <= 1'b0;
    end else if (phase == half - PHASE_W'(1)) begin
      phase <= '0;
      sound <= ~sound;
    end else begin
      phase <= phase + PHASE_W'(1);
    end
  end
endmodule

// File: rtl/sound_arbiter.sv
// Fixed-priority audio event arbiter with one deferred slot and tick-timed tones.
// Optional feature macro: SOUND_MILESTONE_EN (milestone requests participate).
module sound_arbiter
  import sound_pkg::*;
#(
  parameter int JUMP_HALF  = 25000,
  parameter int MILE_HALF  = 12500,
  parameter int OVER_HALF  = 50000,
  parameter int JUMP_TICKS = 6,
  parameter int MILE_TICKS = 10,
  parameter int OVER_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_tick,
  input  logic       req_jump,
  input  logic       req_mile,
  input  logic       req_over,
  output logic       sound,
  output logic       busy,
  output logic [1:0] active_src
);
  state_t             state;
  src_t               act, pend, nxt_act, nxt_pend;
  src_t               req_top, req_2nd;
  logic [TICK_W-1:0]  tick_cnt, ticks_sel;
  logic [PHASE_W-1:0] half_sel;
  logic               mile_eff, tick_end, start, stop;

`ifdef SOUND_MILESTONE_EN
  assign mile_eff = req_mile;
`else
  logic unused_mile;
  assign mile_eff    = 1'b0;
  assign unused_mile = req_mile;
`endif

  always_comb begin
    req_top = SRC_NONE;
    req_2nd = SRC_NONE;
    if (req_over) begin
      req_top = SRC_OVER;
      if (mile_eff)      req_2nd = SRC_MILE;
      else if (req_jump) req_2nd = SRC_JUMP;
    end else if (mile_eff) begin
      req_top = SRC_MILE;
      if (req_jump) req_2nd = SRC_JUMP;
    end else if (req_jump) begin
      req_top = SRC_JUMP;
    end
  end

  always_comb begin
    case (act)
      SRC_MILE: begin half_sel = PHASE_W'(MILE_HALF); ticks_sel = TICK_W'(MILE_TICKS); end
      SRC_OVER: begin half_sel = PHASE_W'(OVER_HALF); ticks_sel = TICK_W'(OVER_TICKS); end
      default:  begin half_sel = PHASE_W'(JUMP_HALF); ticks_sel = TICK_W'(JUMP_TICKS); end
    endcase
  end

  assign tick_end = (state == PLAY) && game_tick && (tick_cnt == ticks_sel - TICK_W'(1));

  // End cycle: incoming request and pending compete, loser is kept as pending.
  // Otherwise an equal-or-higher request (re)starts, anything lower is deferred.
  always_comb begin
    nxt_act  = act;
    nxt_pend = pend;
    start    = 1'b0;
    stop     = 1'b0;
    if (tick_end) begin
      nxt_act  = src_max(req_top, pend);
      nxt_pend = src_max(src_min(req_top, pend), req_2nd);
      start    = (nxt_act != SRC_NONE);
      stop     = !start;
    end else if (req_top != SRC_NONE && req_top >= act) begin
      nxt_act  = req_top;
      nxt_pend = src_max(pend, req_2nd);
      start    = 1'b1;
    end else begin
      nxt_pend = src_max(pend, req_top);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      act      <= SRC_NONE;
      pend     <= SRC_NONE;
      tick_cnt <= '0;
    end else begin
      act  <= nxt_act;
      pend <= nxt_pend;
      if (start) begin
        state    <= PLAY;
        tick_cnt <= '0;
      end else if (stop) begin
        state    <= IDLE;
        tick_cnt <= '0;
      end else if (state == PLAY && game_tick) begin
        tick_cnt <= tick_cnt + TICK_W'(1);
      end
    end
  end

  assign busy       = (state == PLAY);
  assign active_src = act;

  tone_gen u_tone (
    .clk   (clk),
    .rst   (rst),
    .half  (half_sel),
    .clr   (start | stop),
    .en    (busy),
    .sound (sound)
  );
endmodule

// File: tb/tb_sound_arbiter.sv
// Directed self-checking bench for sound_arbiter with shortened tone parameters.
module tb_sound_arbiter;
  localparam int JH = 4, MH = 3, OH = 6, JT = 3, MT = 2, OT = 4;

  logic clk, rst, game_tick, req_jump, req_mile, req_over;
  logic sound, busy;
  logic [1:0] active_src;
  int ncmp = 0, nerr = 0;

  sound_arbiter #(
    .JUMP_HALF(JH), .MILE_HALF(MH), .OVER_HALF(OH),
    .JUMP_TICKS(JT), .MILE_TICKS(MT), .OVER_TICKS(OT)
  ) dut (
    .clk(clk), .rst(rst), .game_tick(game_tick),
    .req_jump(req_jump), .req_mile(req_mile), .req_over(req_over),
    .sound(sound), .busy(busy), .active_src(active_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic s, input logic b, input logic [1:0] a);
    chk({tag, ".sound"}, sound, s);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".src"}, active_src, a);
  endtask

  // Drive one cycle of inputs, then return at the following negedge.
  task automatic cyc(input logic j, input logic m, input logic o, input logic t);
    req_jump = j; req_mile = m; req_over = o; game_tick = t;
    @(posedge clk);
    @(negedge clk);
    req_jump = 0; req_mile = 0; req_over = 0; game_tick = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 1);
  endtask

  initial begin
    rst = 1; game_tick = 0; req_jump = 0; req_mile = 0; req_over = 0;
    repeat (2) @(negedge clk);
    chk3("in_reset", 0, 0, 0);
    rst = 0;
    idle(200);
    chk3("idle", 0, 0, 0);

    // Jump with a tick in the start cycle: that tick must not count.
    cyc(1, 0, 0, 1);
    chk3("jump_start", 0, 1, 1);
    idle(JH - 1);
    chk("jump_pre_toggle", sound, 0);
    idle(1);
    chk("jump_toggle", sound, 1);
    idle(JH);
    chk("jump_toggle2", sound, 0);
    ticks(JT - 1);
    chk3("jump_before_end", sound, 1, 1);
    ticks(1);
    chk3("jump_end", 0, 0, 0);

    // Simultaneous jump+over: over first, then jump with no idle gap.
    cyc(1, 0, 1, 0);
    chk3("both_start", 0, 1, 3);
    ticks(OT - 1);
    chk("both_over_mid", active_src, 3);
    ticks(1);
    chk3("both_handoff", 0, 1, 1);
    idle(JH);
    chk("both_jump_toggle", sound, 1);
    ticks(JT - 1);
    chk("both_jump_busy", busy, 1);
    ticks(1);
    chk3("both_end", 0, 0, 0);

    // Over preempts jump; same-priority request restarts; jump not replayed.
    cyc(1, 0, 0, 0);
    idle(JH);
    chk("pre_jump_sound", sound, 1);
    cyc(0, 0, 1, 0);
    chk3("preempt", 0, 1, 3);
    ticks(2);
    idle(OH - 2);
    chk("over_toggle", sound, 1);
    cyc(0, 0, 1, 0);
    chk3("restart", 0, 1, 3);
    ticks(OT - 1);
    chk("restart_busy", busy, 1);
    ticks(1);
    chk3("preempt_end", 0, 0, 0);
    idle(3);
    chk3("no_replay", 0, 0, 0);

    // Mile then jump during over: pending keeps the higher one.
    cyc(0, 0, 1, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    chk("defer_over", active_src, 3);
    ticks(OT);
`ifdef SOUND_MILESTONE_EN
    chk3("defer_next", 0, 1, 2);
    ticks(MT);
`else
    chk3("defer_next", 0, 1, 1);
    ticks(JT);
`endif
    chk3("defer_end", 0, 0, 0);

    // Lone milestone request from idle.
    cyc(0, 1, 0, 0);
`ifdef SOUND_MILESTONE_EN
    chk3("mile_only", 0, 1, 2);
`else
    chk3("mile_only", 0, 0, 0);
`endif
    ticks(MT);
    chk("mile_only_end", busy, 0);

    // Asynchronous reset mid-tone, then normal replay.
    cyc(1, 0, 0, 0);
    idle(JH);
    chk3("rst_pre", 1, 1, 1);
    rst = 1;
    #1;
    chk3("rst_async", 0, 0, 0);
    #1 rst = 0;
    cyc(1, 0, 0, 0);
    chk3("rst_replay", 0, 1, 1);
    idle(JH);
    chk("rst_replay_toggle", sound, 1);
    ticks(JT);
    chk3("rst_replay_end", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/sound_arbiter.md
# sound_arbiter

Arbiter and sequencer for the single audio output pin (uio_out[7]). Accepts one-cycle event requests from the player controller (jump, game over) and the score module (milestone), selects one by fixed priority, and drives a square-wave tone of source-specific pitch for a source-specific number of 60 Hz game ticks. Holds one deferred request and plays it when the current tone ends. Sits between the game-state blocks and the audio pin, in place of a direct per-event audio path.

## Interface
- JUMP_HALF: 25000; jump tone half-period in clk cycles (≈500 Hz at 25 MHz)
- MILE_HALF: 12500; milestone tone half-period in clk cycles
- OVER_HALF: 50000; game-over tone half-period in clk cycles
- JUMP_TICKS: 6; jump tone duration in game ticks
- MILE_TICKS: 10; milestone tone duration in game ticks
- OVER_TICKS: 30; game-over tone duration in game ticks

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- game_tick  in  1  one-cycle 60 Hz pulse
- req_jump  in  1  one-cycle pulse, jump event
- req_mile  in  1  one-cycle pulse, score milestone event
- req_over  in  1  one-cycle pulse, game-over event
- sound  out  1  square-wave audio output
- busy  out  1  high while a tone plays
- active_src  out  2  source currently playing (0 none, 1 jump, 2 mile, 3 over)

## Operation
- Priority is fixed and equal to source code value: over(3) > mile(2) > jump(1).
- FSM states: IDLE, PLAY.
- IDLE: on any request, go to PLAY with the highest-priority requester; the next highest simultaneous requester goes to the pending slot.
- PLAY, arriving request of higher priority than active: preempt; the new source starts fresh, and the preempted source is discarded and not placed in pending.
- PLAY, arriving request of the same priority as active: restart the tone. The duration count clears, the phase counter clears and sound goes to 0.
- PLAY, arriving request of lower priority: store it in pending if its priority exceeds the current pending value; otherwise drop it.
- Pending is one entry only. A higher-priority deferred request overwrites it.
- Tone end: when the tick count reaches the active source's TICKS, the tone ends.
  - If pending is nonzero, start the pending source on the next cycle and clear pending.
  - Otherwise return to IDLE.
- A new request in the end cycle competes with pending; the winner plays and the loser goes to pending, using the same compare rule.
- Tone generation:
  - The phase counter counts 0..HALF-1 and toggles sound on wrap.
  - sound is forced to 0 on every tone start and whenever the FSM is in IDLE.
- Counter widths:
  - Phase counter is 17 bits; all HALF values must be ≤ 131071.
  - Tick counter is 6 bits; all TICKS values must be in 1..63.

## Timing
- Reset values: sound=0, busy=0, active_src=0, pending=0, all counters 0, state IDLE.
- Request sampled at edge N: busy and active_src update at edge N+1; sound toggles first at edge N+1+HALF.
- Duration: the tone ends on the edge at which the TICKS-th game_tick after start is sampled. A game_tick in the same cycle as the start request is not counted.
- Pending start: the pending source begins exactly one cycle after the end edge. busy stays high throughout, with no idle gap.
- Reset asserted mid-tone: all state clears immediately and asynchronously, and sound goes to 0 without waiting for a clock edge.
- game_tick and a request in the same cycle: the request takes effect and the tick is ignored for the new tone.

## Configuration
- SOUND_MILESTONE_EN defined: req_mile participates in arbitration as specified.
- SOUND_MILESTONE_EN undefined:
  - req_mile is ignored. The port is still present, and the signal is routed to an unused sink.
  - Code 2 never appears on active_src or in pending.
  - MILE_HALF and MILE_TICKS have no effect.

## Structure
- Shared package sound_pkg contains:
  - Source codes SRC_NONE=0, SRC_JUMP=1, SRC_MILE=2, SRC_OVER=3.
  - FSM state encoding.
  - Phase counter width constant (17) and tick counter width constant (6).
- One sub-module, tone_gen: phase counter plus toggle flop, with a load-half-period input, a clear input and an enable input.
- The arbiter owns the FSM, pending register, tick counter and per-source parameter muxing.

## Test plan
- Reset then idle: no requests for 10000 cycles -> sound=0, busy=0, active_src=0.
- req_jump at cycle 100, 6 game_ticks -> active_src=1 from cycle 101; sound toggles every 25000 cycles; busy falls on the 6th tick edge.
- req_jump and req_over in the same cycle -> active_src=3 for 30 ticks, then jump plays the following cycle with active_src=1 for 6 ticks, with no idle cycle.
- req_over during a jump tone -> preempt next cycle, active_src=3, sound restarts at 0; the jump is not replayed afterwards.
- req_mile during an over tone, then req_jump -> pending holds 2, and the milestone plays after the over tone ends; the jump is dropped. Without SOUND_MILESTONE_EN, req_mile never produces active_src=2.
- rst pulse mid-tone -> sound, busy and active_src are 0 asynchronously; the next req_jump plays normally.
